// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver with integrated receive FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        PUSH
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is shown combinationally from storage.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_d;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is allowed only when a pop frees the slot in the same cycle.
    always_comb begin
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        count_d = count;
        if (do_wr && !do_rd) begin
            count_d = count + CW'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CW'(DEPTH));
        end
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (synchroniser, bit timer, frame FSM, error flags) feeding a FWFT receive FIFO.
// Define UART_RX_ERR_COUNT_EN to build the saturating err_cnt counter; otherwise err_cnt is 0.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     rx_serial,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     overflow,
    output logic                     err_led,
    output logic [7:0]               err_cnt
);

    import uart_pkg::*;

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    logic [1:0]        sync_q;
    logic              rx_s;
    rx_state_t         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_bad_q, par_bad_d;
    logic              par_x;
    logic              frame_ev, parity_ev, ovf_ev, any_ev;
    logic              push_c;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_serial};
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    // Frame FSM: after the half-bit start check, every sample lands mid-bit.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        frame_ev  = 1'b0;
        parity_ev = 1'b0;
        ovf_ev    = 1'b0;
        push_c    = 1'b0;
        par_x     = (^shift_q) ^ rx_s;
        case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_d     = '0;
                par_bad_d = 1'b0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (timer_q == T_LAST) begin
                    timer_d   = '0;
                    par_bad_d = (PARITY == PAR_ODD) ? ~par_x : par_x;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    if (!rx_s) begin
                        frame_ev = 1'b1;
                        state_d  = IDLE;
                    end else if (par_bad_q) begin
                        parity_ev = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = PUSH;
                    end
                end
            end
            PUSH: begin
                state_d = IDLE;
                if (!full || rd_en) begin
                    push_c = 1'b1;
                end else begin
                    ovf_ev = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign any_ev = frame_ev | parity_ev | ovf_ev;

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
            err_led    <= 1'b0;
        end else begin
            frame_err  <= frame_ev;
            parity_err <= parity_ev;
            overflow   <= ovf_ev;
            err_led    <= any_ev | (err_led & ~clr_err);
        end
    end

`ifdef UART_RX_ERR_COUNT_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (any_ev && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nRst    (nRst),
        .wr_en   (push_c),
        .wr_data (shift_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one 8N1 instance and one even-parity instance.
module tb_uart_rx_fifo;

    localparam int unsigned CPB = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 4;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       rx = 1'b1, rd_en = 1'b0, clr = 1'b0;
    logic       rx_p = 1'b1, rd_en_p = 1'b0, clr_p = 1'b0;

    logic [DW-1:0] rd_data, rd_data_p;
    logic          empty, full, empty_p, full_p;
    logic [2:0]    count, count_p;
    logic          frame_err, parity_err, overflow, err_led;
    logic          frame_err_p, parity_err_p, overflow_p, err_led_p;
    logic [7:0]    err_cnt, err_cnt_p;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY(0), .DEPTH(DEP)) dut (
        .clk(clk), .nRst(nRst), .rx_serial(rx), .rd_en(rd_en), .clr_err(clr),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow),
        .err_led(err_led), .err_cnt(err_cnt)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY(1), .DEPTH(DEP)) dut_p (
        .clk(clk), .nRst(nRst), .rx_serial(rx_p), .rd_en(rd_en_p), .clr_err(clr_p),
        .rd_data(rd_data_p), .empty(empty_p), .full(full_p), .count(count_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .overflow(overflow_p),
        .err_led(err_led_p), .err_cnt(err_cnt_p)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fe = 0, pe = 0, ov = 0, fe_p = 0, pe_p = 0, ov_p = 0;

    // Count pulse-cycles; a pulse held longer than one cycle shows up as an extra count.
    always @(posedge clk) begin
        if (frame_err)    fe++;
        if (parity_err)   pe++;
        if (overflow)     ov++;
        if (frame_err_p)  fe_p++;
        if (parity_err_p) pe_p++;
        if (overflow_p)   ov_p++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        bit         pop;
        bit         clr;
        int         cnt;
        int         full;
        int         head;
        int         fe;
        int         ov;
        int         led;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Drives one frame starting at a negedge; returns at the negedge just before the stop sample edge.
    task automatic send(input bit p, input logic [7:0] d, input bit use_par,
                        input logic pbit, input logic stop);
        logic [10:0] f;
        int n;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (use_par) begin
            f[9] = pbit;
            f[10] = stop;
            n = 11;
        end else begin
            f[9] = stop;
            n = 10;
        end
        for (int i = 0; i < n; i++) begin
            if (p) rx_p = f[i]; else rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        if (p) rx_p = 1'b1; else rx = 1'b1;
    endtask

    task automatic pop(input int exp, input string nm);
        chk(nm, int'(rd_data), exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic idle();
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_ec;
        //          data   stop pop clr cnt full head  fe ov led
        vt[0] = '{8'hA5, 1'b1, 1, 0, 1, 0, 8'hA5, 0, 0, 0};
        vt[1] = '{8'h3C, 1'b0, 0, 1, 0, 0, 8'h00, 1, 0, 1};
        vt[2] = '{8'h01, 1'b1, 0, 0, 1, 0, 8'h01, 1, 0, 0};
        vt[3] = '{8'h02, 1'b1, 0, 0, 2, 0, 8'h01, 1, 0, 0};
        vt[4] = '{8'h03, 1'b1, 0, 0, 3, 0, 8'h01, 1, 0, 0};
        vt[5] = '{8'h04, 1'b1, 0, 0, 4, 1, 8'h01, 1, 0, 0};
        vt[6] = '{8'h05, 1'b1, 0, 0, 4, 1, 8'h01, 1, 1, 1};

        repeat (3) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);

        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_empty",   int'(empty), 1);
        chk("rst_full",    int'(full), 0);
        chk("rst_count",   int'(count), 0);
        chk("rst_pulses",  int'({frame_err, parity_err, overflow}), 0);
        chk("rst_err_led", int'(err_led), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_empty_p", int'(empty_p), 1);

        // One-clock low glitch on an idle line must be ignored.
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_empty",  int'(empty), 1);
        chk("glitch_errors", fe + pe + ov, 0);
        chk("glitch_led",    int'(err_led), 0);

        for (int i = 0; i < 7; i++) begin
            send(1'b0, vt[i].data, 1'b0, 1'b0, vt[i].stop);
            idle();
            chk($sformatf("v%0d_count", i), int'(count), vt[i].cnt);
            chk($sformatf("v%0d_full", i),  int'(full), vt[i].full);
            chk($sformatf("v%0d_empty", i), int'(empty), (vt[i].cnt == 0) ? 1 : 0);
            if (vt[i].cnt != 0) chk($sformatf("v%0d_head", i), int'(rd_data), vt[i].head);
            chk($sformatf("v%0d_frame_err", i), fe, vt[i].fe);
            chk($sformatf("v%0d_overflow", i),  ov, vt[i].ov);
            chk($sformatf("v%0d_err_led", i),   int'(err_led), vt[i].led);
            if (vt[i].pop) begin
                pop(int'(vt[i].data), $sformatf("v%0d_pop", i));
                chk($sformatf("v%0d_empty_after_pop", i), int'(empty), 1);
                chk($sformatf("v%0d_count_after_pop", i), int'(count), 0);
            end
            if (vt[i].clr) begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                chk($sformatf("v%0d_led_after_clr", i), int'(err_led), 0);
                chk($sformatf("v%0d_cnt_after_clr", i), int'(err_cnt), 0);
            end
        end
        chk("parity_err_never", pe, 0);

        for (int k = 1; k <= 4; k++) pop(k, $sformatf("drain_%0d", k));
        chk("drain_empty", int'(empty), 1);
`ifdef UART_RX_ERR_COUNT_EN
        exp_ec = 1;
`else
        exp_ec = 0;
`endif
        chk("err_cnt_after_ovf", int'(err_cnt), exp_ec);

        // Refill, then pop in the exact PUSH cycle of 0x55 so it is accepted while full.
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 8'(8'h11 + k), 1'b0, 1'b0, 1'b1);
            idle();
        end
        chk("refill_full", int'(full), 1);
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        idle();
        chk("push_pop_count", int'(count), 4);
        chk("push_pop_full",  int'(full), 1);
        chk("push_pop_no_ovf", ov, 1);
        pop(8'h12, "pp_pop0");
        pop(8'h13, "pp_pop1");
        pop(8'h14, "pp_pop2");
        pop(8'h55, "pp_pop3_last");
        chk("pp_empty", int'(empty), 1);

        // Even parity: 0x07 has three ones, so parity bit 1 is correct and 0 is wrong.
        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle();
        chk("par_ok_count", int'(count_p), 1);
        chk("par_ok_head",  int'(rd_data_p), 8'h07);
        chk("par_ok_no_err", pe_p, 0);
        send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        idle();
        chk("par_bad_pulse", pe_p, 1);
        chk("par_bad_count", int'(count_p), 1);
        chk("par_bad_led",   int'(err_led_p), 1);
        chk("par_other_errs", fe_p + ov_p, 0);
        chk("par_err_cnt",   int'(err_cnt_p), exp_ec);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
